zpu_sd_bridge: RTL

Bridge between the ZPU firmware I/O registers and the hps_io SD sector interface for the Atari 5200 core. It owns the 512-byte sector buffer, the buffer pointer, the LBA register and the block read/write handshake toward hps_io. It also tracks mount and file status for the firmware. It sits between hps_io (sd_* / img_* ports) and atari5200top (ZPU_* ports).

---
 rtl/zpu_sd_bridge.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/zpu_sd_bridge.sv
// zpu_sd_bridge
// Bridges the ZPU firmware I/O registers to the hps_io SD sector interface.
// Owns the 512-byte sector buffer, the ZPU-side buffer pointer, the LBA
// register, the block read/write request handshake and mount/file status.
//
// Ports:
//   CLK, RESET_N            system clock, asynchronous active-low reset
//   CORE_RESET              core reset level; resamples the mounted bit
//   ZPU_OUT2                control: [0] lba_sel, [1] block_rd, [2] block_wr
//   ZPU_OUT3                firmware write data (LBA or buffer byte)
//   ZPU_WR                  write strobes: [5] io_wr (ptr clear), [6] data_wr
//   ZPU_RD                  read strobes: [2] data_rd (ptr advance on fall)
//   ZPU_IN2                 status {readonly, filetype, fileno, mounted, io_done}
//   ZPU_IN3                 lba_sel ? filesize : buffer byte at ptr
//   SD_LBA, SD_RD, SD_WR    sector request toward hps_io
//   SD_ACK                  hps_io transfer active
//   SD_BUFF_ADDR/DOUT/WR    hps_io buffer port (write side)
//   SD_BUFF_DIN             hps_io buffer port read data (1-cycle registered)
//   IMG_MOUNTED, IMG_SIZE   mount pulse and image size (low 32 bits used)
//   IOCTL_INDEX             file index; [7:6] give the filetype
module zpu_sd_bridge #(
    parameter int unsigned BUF_AW = 9
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CORE_RESET,
    input  logic [31:0]       ZPU_OUT2,
    input  logic [31:0]       ZPU_OUT3,
    input  logic [15:0]       ZPU_WR,
    input  logic [15:0]       ZPU_RD,
    output logic [7:0]        ZPU_IN2,
    output logic [31:0]       ZPU_IN3,
    output logic [31:0]       SD_LBA,
    output logic              SD_RD,
    output logic              SD_WR,
    input  logic              SD_ACK,
    input  logic [BUF_AW-1:0] SD_BUFF_ADDR,
    input  logic [7:0]        SD_BUFF_DOUT,
    input  logic              SD_BUFF_WR,
    output logic [7:0]        SD_BUFF_DIN,
    input  logic              IMG_MOUNTED,
    input  logic [63:0]       IMG_SIZE,
    input  logic [7:0]        IOCTL_INDEX
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // Sector buffer and its two registered read ports
    logic [7:0] buf_mem [0:(1<<BUF_AW)-1];
    logic [7:0] buf_a_q;
    logic [7:0] buf_b_q;

    // Datapath / status registers
    logic [BUF_AW-1:0] ptr_q, ptr_d;
    logic [31:0]       lba_q, lba_d;
    logic              w1_q, w1_d;
    logic              w2_q, w2_d;
    logic              r1_q, r1_d;
    logic              inc_q, inc_d;
    logic              blk_rd_prev_q, blk_rd_prev_d;
    logic              blk_wr_prev_q, blk_wr_prev_d;
    logic              ack_prev_q, ack_prev_d;
    logic              mnt_prev_q, mnt_prev_d;
    logic              mounted_q, mounted_d;
    logic [2:0]        fileno_q, fileno_d;
    logic [1:0]        filetype_q, filetype_d;
    logic              readonly_q, readonly_d;
    logic [31:0]       filesize_q, filesize_d;

    // Block request FSM
    state_t state_q;
    logic   sd_rd_q;
    logic   sd_wr_q;
    logic   io_done_q;

    // Combinational event decode
    logic lba_sel;
    logic wr_fire;
    logic rd_fall;
    logic buf_b_we;
    logic blk_rd_rise;
    logic blk_wr_rise;
    logic ack_fall;
    logic mount_rise;

    always_comb begin
        lba_sel     = ZPU_OUT2[0];
        wr_fire     = w1_q & ~w2_q;
        rd_fall     = r1_q & ~ZPU_RD[2];
        buf_b_we    = wr_fire & ~lba_sel;
        blk_rd_rise = ZPU_OUT2[1] & ~blk_rd_prev_q;
        blk_wr_rise = ZPU_OUT2[2] & ~blk_wr_prev_q;
        ack_fall    = ack_prev_q & ~SD_ACK;
        mount_rise  = IMG_MOUNTED & ~mnt_prev_q;
    end

    always_comb begin
        w1_d          = ZPU_WR[6];
        w2_d          = w1_q;
        r1_d          = ZPU_RD[2];
        blk_rd_prev_d = ZPU_OUT2[1];
        blk_wr_prev_d = ZPU_OUT2[2];
        ack_prev_d    = SD_ACK;
        mnt_prev_d    = IMG_MOUNTED;

        // Byte writes advance the pointer one cycle after the write itself,
        // so the buffer write uses the pre-increment address.
        inc_d = buf_b_we;

        lba_d = lba_q;
        if (wr_fire && lba_sel) begin
            lba_d = ZPU_OUT3;
        end

        ptr_d = ptr_q;
        if (inc_q || rd_fall) begin
            ptr_d = ptr_q + 1'b1;
        end
        if (ZPU_WR[5]) begin
            ptr_d = '0;
        end

        mounted_d  = mounted_q;
        fileno_d   = fileno_q;
        filetype_d = filetype_q;
        readonly_d = readonly_q;
        filesize_d = filesize_q;
        if (mount_rise) begin
            mounted_d  = ~mounted_q;
            fileno_d   = '0;
            filetype_d = IOCTL_INDEX[7:6];
            readonly_d = 1'b1;
            filesize_d = IMG_SIZE[31:0];
        end
        // Core reset re-derives the mounted bit from the image size and
        // overrides any toggle from a coincident mount edge.
        if (CORE_RESET) begin
            mounted_d = |IMG_SIZE[31:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_q         <= '0;
            lba_q         <= '0;
            w1_q          <= 1'b0;
            w2_q          <= 1'b0;
            r1_q          <= 1'b0;
            inc_q         <= 1'b0;
            blk_rd_prev_q <= 1'b0;
            blk_wr_prev_q <= 1'b0;
            ack_prev_q    <= 1'b0;
            mnt_prev_q    <= 1'b0;
            mounted_q     <= 1'b0;
            fileno_q      <= '0;
            filetype_q    <= '0;
            readonly_q    <= 1'b1;
            filesize_q    <= '0;
        end else begin
            ptr_q         <= ptr_d;
            lba_q         <= lba_d;
            w1_q          <= w1_d;
            w2_q          <= w2_d;
            r1_q          <= r1_d;
            inc_q         <= inc_d;
            blk_rd_prev_q <= blk_rd_prev_d;
            blk_wr_prev_q <= blk_wr_prev_d;
            ack_prev_q    <= ack_prev_d;
            mnt_prev_q    <= mnt_prev_d;
            mounted_q     <= mounted_d;
            fileno_q      <= fileno_d;
            filetype_q    <= filetype_d;
            readonly_q    <= readonly_d;
            filesize_q    <= filesize_d;
        end
    end

    // Request edges seen outside IDLE are dropped; the edge history flops
    // above still track the inputs so a held level never re-triggers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            sd_rd_q   <= 1'b0;
            sd_wr_q   <= 1'b0;
            io_done_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (blk_rd_rise) begin
                        sd_rd_q   <= 1'b1;
                        io_done_q <= 1'b0;
                        state_q   <= ST_REQ;
                    end else if (blk_wr_rise) begin
                        sd_wr_q   <= 1'b1;
                        io_done_q <= 1'b0;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (SD_ACK) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (ack_fall) begin
                        io_done_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // True dual-port buffer: port A for hps_io, port B for the ZPU pointer.
    // Contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (SD_BUFF_WR) begin
            buf_mem[SD_BUFF_ADDR] <= SD_BUFF_DOUT;
        end
        buf_a_q <= buf_mem[SD_BUFF_ADDR];
        if (buf_b_we) begin
            buf_mem[ptr_q] <= ZPU_OUT3[7:0];
        end
        buf_b_q <= buf_mem[ptr_q];
    end

    assign SD_LBA      = lba_q;
    assign SD_RD       = sd_rd_q;
    assign SD_WR       = sd_wr_q;
    assign SD_BUFF_DIN = buf_a_q;
    assign ZPU_IN2     = {readonly_q, filetype_q, fileno_q, mounted_q, io_done_q};
    assign ZPU_IN3     = lba_sel ? filesize_q : {24'b0, buf_b_q};

    logic unused_inputs;
    assign unused_inputs = ^{ZPU_OUT2[31:3], ZPU_WR[15:7], ZPU_WR[4:0],
                             ZPU_RD[15:3], ZPU_RD[1:0], IMG_SIZE[63:32],
                             IOCTL_INDEX[5:0]};

endmodule
